// File: rtl/regbus_arb.sv
// Two-master round-robin arbiter/sequencer for the peripheral register bus.
// Latency: strobe+gnt one cycle after req is sampled; read return two cycles after the strobe.
// Backpressure: one command in flight; requests wait in IDLE, reads time out after TIMEOUT cycles.
module regbus_arb #(
   parameter int          TIMEOUT  = 15,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [3:0]  m0_be,
   input  logic [15:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic [31:0] m0_rdata,
   output logic        m0_rvalid,
   output logic        m0_rerr,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [3:0]  m1_be,
   input  logic [15:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic [31:0] m1_rdata,
   output logic        m1_rvalid,
   output logic        m1_rerr,
   output logic        s_wr_en,
   output logic [3:0]  s_be,
   output logic [15:0] s_wr_addr,
   output logic [31:0] s_wdata,
   output logic        s_rd_en,
   output logic [15:0] s_rd_addr,
   input  logic [31:0] s_rdata,
   input  logic        s_rd_rdy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CMD   = 2'd1;
   localparam logic [1:0] S_RWAIT = 2'd2;

   // Timeout fires once the incremented wait count would reach TIMEOUT-1.
   localparam logic [8:0] TO_LAST = 9'(TIMEOUT - 1);

   logic [1:0]  state;
   logic        last_gnt;
   logic        owner;
   logic [7:0]  cnt;

   logic        sel;
   logic        sel_we;
   logic [3:0]  sel_be;
   logic [15:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        cnt_done;

   // Pick the winning master and mux its command fields; contention goes to the master not granted last.
   always_comb begin
      sel       = m1_req && (!m0_req || !last_gnt);
      sel_we    = sel ? m1_we    : m0_we;
      sel_be    = sel ? m1_be    : m0_be;
      sel_addr  = sel ? m1_addr  : m0_addr;
      sel_wdata = sel ? m1_wdata : m0_wdata;
      cnt_done  = ({1'b0, cnt} + 9'd1) >= TO_LAST;
   end

   // Sequencer: issue one command, then wait for read data or time out; pulses default low each cycle.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state     <= S_IDLE;
         last_gnt  <= 1'b1;
         owner     <= 1'b0;
         cnt       <= 8'd0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rdata  <= 32'd0;
         m1_rdata  <= 32'd0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rerr   <= 1'b0;
         m1_rerr   <= 1'b0;
         s_wr_en   <= 1'b0;
         s_be      <= 4'd0;
         s_wr_addr <= 16'd0;
         s_wdata   <= 32'd0;
         s_rd_en   <= 1'b0;
         s_rd_addr <= 16'd0;
      end else begin
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rerr   <= 1'b0;
         m1_rerr   <= 1'b0;
         s_wr_en   <= 1'b0;
         s_rd_en   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (m0_req || m1_req) begin
                  if (sel_we) begin
                     s_wr_en   <= 1'b1;
                     s_be      <= sel_be;
                     s_wr_addr <= sel_addr;
                     s_wdata   <= sel_wdata;
                  end else begin
                     s_rd_en   <= 1'b1;
                     s_rd_addr <= sel_addr;
                  end
                  m0_gnt   <= !sel;
                  m1_gnt   <= sel;
                  last_gnt <= sel;
                  owner    <= sel;
                  state    <= S_CMD;
               end
            end
            S_CMD: begin
               // The read strobe is still high here, so it tells us which way to go.
               if (s_rd_en) begin
                  cnt   <= 8'd0;
                  state <= S_RWAIT;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RWAIT: begin
               if (s_rd_rdy || cnt_done) begin
                  if (owner) begin
                     m1_rdata  <= s_rd_rdy ? s_rdata : ERR_DATA;
                     m1_rvalid <= 1'b1;
                     m1_rerr   <= !s_rd_rdy;
                  end else begin
                     m0_rdata  <= s_rd_rdy ? s_rdata : ERR_DATA;
                     m0_rvalid <= 1'b1;
                     m0_rerr   <= !s_rd_rdy;
                  end
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regbus_arb.sv
// Self-checking bench for regbus_arb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-timing model.
// Model works from cycle numbers: when the bus is free, when the read window closes.
module tb_regbus_arb;
   localparam int          TO   = 15;
   localparam logic [31:0] ERRD = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [3:0]  m0_be = 0, m1_be = 0;
   logic [15:0] m0_addr = 0, m1_addr = 0;
   logic [31:0] m0_wdata = 0, m1_wdata = 0;
   logic        m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_wr_en, s_rd_en;
   logic [3:0]  s_be;
   logic [15:0] s_wr_addr, s_rd_addr;
   logic [31:0] s_wdata;
   logic [31:0] s_rdata = 0;
   logic        s_rd_rdy = 0;

   always #5 clk = ~clk;

   regbus_arb #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
      .clk(clk), .rstb(rstb),
      .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rerr(m0_rerr),
      .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rerr(m1_rerr),
      .s_wr_en(s_wr_en), .s_be(s_be), .s_wr_addr(s_wr_addr), .s_wdata(s_wdata),
      .s_rd_en(s_rd_en), .s_rd_addr(s_rd_addr), .s_rdata(s_rdata), .s_rd_rdy(s_rd_rdy)
   );

   int total = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic logic [7:0] ctl_now();
      return {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr, s_wr_en, s_rd_en};
   endfunction
   function automatic logic [67:0] bus_now();
      return {s_be, s_wr_addr, s_wdata, s_rd_addr};
   endfunction

   // ---------------- behavioural model ----------------
   int          cyc = 0;
   int          busy_until = 0;
   int          win_lo = 0, win_hi = 0;
   bit          pend = 0, own = 0, last = 1;
   logic [7:0]  e_ctl = 0;
   logic [67:0] e_bus = 0;
   logic [31:0] e_rd0 = 0, e_rd1 = 0;

   task automatic deliver(input logic [31:0] d, input logic err);
      if (own) begin e_ctl[4] = 1'b1; e_ctl[2] = err; e_rd1 = d; end
      else     begin e_ctl[5] = 1'b1; e_ctl[3] = err; e_rd0 = d; end
      pend = 0;
      busy_until = cyc + 1;
   endtask

   always @(negedge clk) begin
      bit sel;
      cyc++;
      if (!rstb) begin
         chk("rst_ctl", ctl_now(), 0);
         chk("rst_bus", bus_now(), 0);
         chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
         e_ctl = 0; e_bus = 0; e_rd0 = 0; e_rd1 = 0;
         last = 1; pend = 0; busy_until = 0;
      end else begin
         chk("ctl", ctl_now(), e_ctl);
         chk("bus", bus_now(), e_bus);
         chk("rdata", {m0_rdata, m1_rdata}, {e_rd0, e_rd1});
         e_ctl = 0;
         if (pend && cyc >= win_lo && cyc <= win_hi) begin
            if (s_rd_rdy) deliver(s_rdata, 1'b0);
            else if (cyc == win_hi) deliver(ERRD, 1'b1);
         end else if (!pend && cyc >= busy_until && (m0_req || m1_req)) begin
            sel  = (m0_req && m1_req) ? !last : m1_req;
            last = sel;
            e_ctl[7] = !sel;
            e_ctl[6] = sel;
            if (sel ? m1_we : m0_we) begin
               e_ctl[1] = 1'b1;
               e_bus[67:16] = sel ? {m1_be, m1_addr, m1_wdata} : {m0_be, m0_addr, m0_wdata};
               busy_until = cyc + 2;
            end else begin
               e_ctl[0] = 1'b1;
               e_bus[15:0] = sel ? m1_addr : m0_addr;
               own = sel;
               pend = 1;
               win_lo = cyc + 2;
               win_hi = cyc + ((TO < 2) ? 2 : TO);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int          cd = 0;
   int          rf_mode = 0;
   bit          spur = 0, rnd_on = 0;
   logic [31:0] rf_data = 32'hA500_5A03;

   // Advance one cycle; then act as the register file and (when enabled) as two random masters.
   task automatic step();
      logic rdy;
      @(posedge clk); #1;
      rdy = 1'b0;
      if (cd > 0) begin cd--; if (cd == 0) rdy = 1'b1; end
      if (spur) rdy = 1'b1;
      spur = 0;
      if (rnd_on && $urandom_range(0, 29) == 0) rdy = 1'b1;
      if (s_rd_en && rf_mode != 0) cd = (rf_mode == 1) ? 1 : int'($urandom_range(1, 18));
      s_rd_rdy = rdy;
      s_rdata  = rnd_on ? $urandom : rf_data;
      if (rnd_on) begin
         if (m0_req && (m0_gnt || $urandom_range(0, 39) == 0)) m0_req = 0;
         if (!m0_req && $urandom_range(0, 3) == 0) begin
            m0_req = 1; m0_we = $urandom_range(0, 1) == 1; m0_be = 4'($urandom);
            m0_addr = 16'($urandom); m0_wdata = $urandom;
         end
         if (m1_req && (m1_gnt || $urandom_range(0, 39) == 0)) m1_req = 0;
         if (!m1_req && $urandom_range(0, 3) == 0) begin
            m1_req = 1; m1_we = $urandom_range(0, 1) == 1; m1_be = 4'($urandom);
            m1_addr = 16'($urandom); m1_wdata = $urandom;
         end
      end
   endtask

   initial begin
      repeat (3) step();
      chk("reset_outputs", {ctl_now(), bus_now()}, 0);
      rstb = 1'b1;
      step();

      // Single write from m0.
      m0_req = 1; m0_we = 1; m0_be = 4'b0010; m0_addr = 16'h0000; m0_wdata = 32'h0000_5A00;
      step();
      chk("wr_strobe_gnt", ctl_now(), 8'b1000_0010);
      chk("wr_fields", {s_be, s_wr_addr, s_wdata}, {4'b0010, 16'h0000, 32'h0000_5A00});
      m0_req = 0;
      step();
      chk("wr_strobe_drop", ctl_now(), 0);

      // Single read from m1 against a one-cycle register file.
      rf_mode = 1;
      m1_req = 1; m1_we = 0; m1_addr = 16'h0010;
      step();
      chk("rd_strobe_gnt", ctl_now(), 8'b0100_0001);
      chk("rd_addr", s_rd_addr, 16'h0010);
      m1_req = 0;
      step();
      step();
      chk("rd_rvalid", ctl_now(), 8'b0001_0000);
      chk("rd_data", m1_rdata, 32'hA500_5A03);
      step();
      chk("rd_rvalid_drop", ctl_now(), 0);

      // Contention: both masters hold write requests; grants alternate every 2 cycles.
      m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1; m1_be = 4'hF; m1_addr = 16'h0004; m1_wdata = 32'h1234_5678;
      for (int i = 1; i <= 7; i++) begin
         step();
         chk("contention_gnt", {m0_gnt, m1_gnt}, {1'(i == 1 || i == 5), 1'(i == 3 || i == 7)});
      end
      m0_req = 0; m1_req = 0;
      step();

      // Timeout: no read data ever returns.
      rf_mode = 0;
      m0_req = 1; m0_we = 0; m0_addr = 16'h0020;
      step();
      chk("to_gnt", m0_gnt, 1'b1);
      m0_req = 0;
      for (int j = 1; j <= TO; j++) begin
         step();
         chk("to_rvalid", {m0_rvalid, m1_rvalid}, {1'(j == TO), 1'b0});
      end
      chk("to_err", {m0_rerr, m0_rdata}, {1'b1, ERRD});
      m0_req = 1; m0_we = 1; m0_be = 4'h3; m0_addr = 16'h0008; m0_wdata = 32'hCAFE_0001;
      step();
      chk("to_next_write", ctl_now(), 8'b1000_0010);
      m0_req = 0;
      step();

      // Unsolicited rd_rdy while idle.
      spur = 1;
      step();
      step();
      chk("spur_none", ctl_now(), 0);
      step();
      chk("spur_none2", ctl_now(), 0);

      // Reset in the middle of a read wait.
      m1_req = 1; m1_we = 0; m1_addr = 16'h0030;
      step();
      m1_req = 0;
      repeat (3) step();
      rstb = 1'b0;
      #1;
      chk("midrst_ctl", ctl_now(), 0);
      chk("midrst_bus", bus_now(), 0);
      step();
      rstb = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("midrst_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
      end
      m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
      step();
      chk("midrst_first_gnt", {m0_gnt, m1_gnt}, 2'b10);
      m0_req = 0; m1_req = 0;
      step();
      step();

      // Randomized traffic checked by the model every cycle.
      rnd_on = 1;
      for (int n = 0; n < 4000; n++) begin
         if (n % 250 == 0) rf_mode = int'($urandom_range(1, 2));
         step();
         if ($urandom_range(0, 499) == 0) begin
            rstb = 1'b0;
            cd = 0;
            step();
            rstb = 1'b1;
         end
      end
      rnd_on = 0;
      step();
      step();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
      $fatal(1);
   end

endmodule

// File: doc/regbus_arb.md
Name: regbus_arb

Overview:
- Two-master arbiter and sequencer for the single peripheral register bus (wr_en/be/wr_addr/wdata, rd_en/rd_addr/rdata/rd_rdy) driven into the UART register file.
- Master 0 is the CPU load/store path. Master 1 is the debug/boot loader path.
- Accepts one command at a time with round-robin priority, drives a single-cycle bus strobe, waits for read data and routes it back to the originating master.
- Returns an error response with a timeout if no read data arrives.

Parameters:
- TIMEOUT, 15: maximum cycles spent in RWAIT before an error response; legal range 1..255.
- ERR_DATA, 32'h0000_0000: rdata value returned on timeout.

Ports:
- clk  in  1  system clock, rising edge
- rstb  in  1  asynchronous active-low reset
- mN_req  in  1  master N command request (N=0,1); held until mN_gnt
- mN_we  in  1  1=write, 0=read; stable while mN_req
- mN_be  in  4  write byte enables
- mN_addr  in  16  register address
- mN_wdata  in  32  write data
- mN_gnt  out  1  one-cycle pulse: command issued to bus
- mN_rdata  out  32  read return data
- mN_rvalid  out  1  one-cycle pulse: mN_rdata valid
- mN_rerr  out  1  qualifies mN_rvalid; 1=read timed out
- s_wr_en  out  1  bus write strobe
- s_be  out  4  bus byte enables
- s_wr_addr  out  16  bus write address
- s_wdata  out  32  bus write data
- s_rd_en  out  1  bus read strobe
- s_rd_addr  out  16  bus read address
- s_rdata  in  32  bus read data, valid when s_rd_rdy=1
- s_rd_rdy  in  1  bus read-data-ready pulse

Behaviour:
- All outputs are registered.
- Reset values: every output is 0. State=IDLE. last_gnt=1, so master 0 wins the first contention. Timeout counter=0.
- Reset asserted mid-operation aborts everything: no gnt and no rvalid are produced for the aborted command.
- FSM states: IDLE, CMD, RWAIT.
- IDLE:
  - If any req=1, select a master: the single requester, or on contention the master != last_gnt.
  - Latch the selected master's we/be/addr/wdata onto the s_* buses. Assert s_wr_en (we=1) or s_rd_en (we=0) for the next cycle.
  - Assert mN_gnt for the next cycle. Update last_gnt. Go to CMD.
- CMD (lasts exactly 1 cycle):
  - Strobe and gnt are high in this cycle only. Next cycle they return to 0.
  - After a write, go to IDLE. After a read, clear the counter and go to RWAIT.
- Address and data outputs hold their last values between commands. s_wdata/s_be are driven only by writes; s_rd_addr only by reads.
- RWAIT:
  - If s_rd_rdy=1, register s_rdata into the owning master's mN_rdata, pulse mN_rvalid next cycle with rerr=0, and go to IDLE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no rd_rdy, pulse rvalid with rerr=1 and rdata=ERR_DATA, and go to IDLE.
  - s_rd_rdy in IDLE or CMD is ignored.
- Timing, with req first sampled at edge N:
  - strobe and gnt are high in cycle N+1.
  - Against the register file (rd_rdy one cycle after rd_en), rd_rdy arrives in N+2 and rvalid is high in N+3.
  - Write throughput: 1 command per 2 cycles. Read throughput: 1 per 3 cycles.
  - A new req may be accepted in the same cycle rvalid is high.
- Only the owning master ever sees rvalid. mN_rdata holds until that master's next read return.
- req dropped before gnt is legal: the command is simply not issued.
- Changing command fields while req=1 and gnt not yet seen is illegal.
- At most one outstanding command in total. The master must not expect a write acknowledgement beyond gnt.

Test Plan:
- Single write: m0 req, we=1, be=4'b0010, addr=0, wdata=32'h0000_5A00 → s_wr_en high for exactly 1 cycle, one cycle after req, with those values. m0_gnt pulses in the same cycle. No activity on m1.
- Single read against a regfile model (rd_rdy = rd_en delayed 1, rdata=32'hA5_00_5A_03) → s_rd_en 1 cycle. m1_rvalid=1 with rdata=32'hA500_5A03 and rerr=0, 3 cycles after req. m0_rvalid stays 0.
- Contention: m0 and m1 both hold write req continuously for 4 commands → grants alternate m0,m1,m0,m1 after reset, spaced 2 cycles apart.
- Timeout: read with s_rd_rdy tied 0, TIMEOUT=15 → rvalid with rerr=1 and rdata=ERR_DATA, exactly TIMEOUT cycles after CMD. A following write is then accepted normally.
- Late/unsolicited rd_rdy: pulse s_rd_rdy in IDLE → no rvalid to either master, no state change.
- Reset mid-read: deassert rstb during RWAIT → all outputs 0 immediately. After release, no rvalid appears for the aborted read. The first contention is granted to m0.
